// File: rtl/bios_dl_sequencer_if.sv
// -----------------------------------------------------------------------------
// bios_dl_sequencer_if
// Bundles the data_io download stream and the BIOS burst handshake.
//   slave  : sequencer view (consumes ioctl_*, bios_req; drives bios_* results)
//   master : environment view (data_io + SDRAM-side BIOS loader)
// Optional: BIOS_DL_CHECKSUM_EN adds the 16-bit checksum signal.
// -----------------------------------------------------------------------------
interface bios_dl_sequencer_if #(
  parameter int unsigned ADDR_W = 13
);
  logic              ioctl_download;
  logic [7:0]        ioctl_index;
  logic              ioctl_wr;
  logic [24:0]       ioctl_addr;
  logic [7:0]        ioctl_dout;
  logic [ADDR_W-1:0] bios_addr;
  logic [15:0]       bios_din;
  logic              bios_wr;
  logic              bios_req;
  logic              bios_loaded;
  logic              overflow;
`ifdef BIOS_DL_CHECKSUM_EN
  logic [15:0]       checksum;
`endif

  modport slave (
    input  ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    input  bios_req,
    output bios_addr, bios_din, bios_wr, bios_loaded, overflow
`ifdef BIOS_DL_CHECKSUM_EN
    , output checksum
`endif
  );

  modport master (
    output ioctl_download, ioctl_index, ioctl_wr, ioctl_addr, ioctl_dout,
    output bios_req,
    input  bios_addr, bios_din, bios_wr, bios_loaded, overflow
`ifdef BIOS_DL_CHECKSUM_EN
    , input checksum
`endif
  );
endinterface

// File: rtl/bios_dl_sequencer.sv
// -----------------------------------------------------------------------------
// bios_dl_sequencer
// Pairs ioctl bytes into little-endian 16-bit words, buffers them in a
// two-bank ping-pong buffer and drains each full bank as one burst to the
// BIOS loader under the bios_wr/bios_req handshake.
// Ports:
//   clk_sys : clock (clk_sdr at top level)
//   reset   : asynchronous, active-high reset
//   bus     : bios_dl_sequencer_if.slave (ioctl_* in, bios_req in,
//             bios_addr/bios_din/bios_wr/bios_loaded/overflow out)
// Optional: define BIOS_DL_CHECKSUM_EN to add bus.checksum (sum of streamed
// words modulo 2^16).
// -----------------------------------------------------------------------------
module bios_dl_sequencer #(
  parameter int unsigned BLOCK_WORDS = 32,
  parameter int unsigned ADDR_W      = 13,
  parameter logic [7:0]  DL_INDEX    = 8'd0
) (
  input logic                clk_sys,
  input logic                reset,
  bios_dl_sequencer_if.slave bus
);

  localparam int unsigned PW = $clog2(BLOCK_WORDS);
  localparam logic [PW-1:0] LAST = PW'(BLOCK_WORDS - 1);

  typedef enum logic [1:0] {S_IDLE, S_ARM, S_STREAM, S_WAIT_REL} state_t;

  state_t            r_state;
  logic              r_act;
  logic [7:0]        r_low;
  logic              r_low_pend;
  logic              r_pad;
  logic              r_flush;
  logic [PW-1:0]     r_wptr;
  logic              r_wbank;
  logic [PW-1:0]     r_rptr;
  logic              r_rbank;
  logic [1:0]        r_full;
  logic [ADDR_W-1:0] r_bios_addr;
  logic [15:0]       r_bios_din;
  logic              r_bios_wr;
  logic              r_loaded;
  logic              r_overflow;
  logic [15:0]       r_mem [2*BLOCK_WORDS];
`ifdef BIOS_DL_CHECKSUM_EN
  logic [15:0]       r_checksum;
`endif

  logic          w_act, w_start, w_end;
  logic          w_even_wr, w_odd_wr;
  logic          w_wvalid, w_wdo, w_drop, w_wlast;
  logic [15:0]   w_wdata;
  logic [PW:0]   w_wr_idx, w_rd_idx;
  logic          w_unused;

  // Download qualification and edge detection against the registered copy
  assign w_act     = bus.ioctl_download & (bus.ioctl_index == DL_INDEX);
  assign w_start   = w_act & ~r_act;
  assign w_end     = ~w_act & r_act;
  assign w_even_wr = w_act & bus.ioctl_wr & ~bus.ioctl_addr[0];
  assign w_odd_wr  = w_act & bus.ioctl_wr & bus.ioctl_addr[0];

  // Only bit 0 of the byte address matters; word position comes from r_wptr
  assign w_unused  = ^bus.ioctl_addr[24:1];

  // Word source: pad fill, completed byte pair, or trailing low byte at end
  always_comb begin
    w_wvalid = 1'b0;
    w_wdata  = 16'hFFFF;
    if (r_pad) begin
      w_wvalid = (r_wptr != '0);
    end else if (w_odd_wr) begin
      w_wvalid = 1'b1;
      w_wdata  = {bus.ioctl_dout, r_low};
    end else if (w_end && r_low_pend) begin
      w_wvalid = 1'b1;
      w_wdata  = {8'hFF, r_low};
    end
  end

  assign w_wdo    = w_wvalid & ~r_full[r_wbank] & ~w_start;
  assign w_drop   = w_wvalid & r_full[r_wbank] & ~w_start;
  assign w_wlast  = (r_wptr == LAST);
  assign w_wr_idx = {r_wbank, r_wptr};
  assign w_rd_idx = {r_rbank, r_rptr};

  // Ping-pong buffer storage (no reset: validity is tracked by r_full)
  always_ff @(posedge clk_sys) begin
    if (w_wdo) r_mem[w_wr_idx] <= w_wdata;
  end

  // Writer pointers, drain FSM and status flags
  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_act       <= 1'b0;
      r_low       <= 8'h00;
      r_low_pend  <= 1'b0;
      r_pad       <= 1'b0;
      r_flush     <= 1'b0;
      r_wptr      <= '0;
      r_wbank     <= 1'b0;
      r_rptr      <= '0;
      r_rbank     <= 1'b0;
      r_full      <= 2'b00;
      r_bios_addr <= '0;
      r_bios_din  <= 16'h0000;
      r_bios_wr   <= 1'b0;
      r_loaded    <= 1'b0;
      r_overflow  <= 1'b0;
`ifdef BIOS_DL_CHECKSUM_EN
      r_checksum  <= 16'h0000;
`endif
    end else begin
      r_act <= w_act;
      if (w_start) begin
        // New download aborts any burst in flight and discards buffered data
        r_state     <= S_IDLE;
        r_bios_wr   <= 1'b0;
        r_low_pend  <= 1'b0;
        r_pad       <= 1'b0;
        r_flush     <= 1'b0;
        r_wptr      <= '0;
        r_wbank     <= 1'b0;
        r_rptr      <= '0;
        r_rbank     <= 1'b0;
        r_full      <= 2'b00;
        r_bios_addr <= '0;
        r_loaded    <= 1'b0;
        r_overflow  <= 1'b0;
`ifdef BIOS_DL_CHECKSUM_EN
        r_checksum  <= 16'h0000;
`endif
      end else begin
        if (w_even_wr) begin
          r_low      <= bus.ioctl_dout;
          r_low_pend <= 1'b1;
        end else if (w_odd_wr || w_end) begin
          r_low_pend <= 1'b0;
        end

        // Pad runs until the partial bank closes (wptr wraps to 0)
        if (w_end) begin
          r_pad <= 1'b1;
        end else if (r_pad && (r_wptr == '0)) begin
          r_pad   <= 1'b0;
          r_flush <= 1'b1;
        end

        if (w_wdo) begin
          if (w_wlast) begin
            r_full[r_wbank] <= 1'b1;
            r_wbank         <= ~r_wbank;
            r_wptr          <= '0;
          end else begin
            r_wptr <= r_wptr + PW'(1);
          end
        end
        if (w_drop) r_overflow <= 1'b1;

        case (r_state)
          S_IDLE: begin
            if (r_full[r_rbank]) r_state <= S_ARM;
          end
          S_ARM: begin
            r_bios_wr <= 1'b1;
            r_rptr    <= '0;
            r_state   <= S_STREAM;
          end
          S_STREAM: begin
            if (bus.bios_req) begin
              r_bios_din <= r_mem[w_rd_idx];
              r_rptr     <= r_rptr + PW'(1);
`ifdef BIOS_DL_CHECKSUM_EN
              if (!r_loaded) r_checksum <= r_checksum + r_mem[w_rd_idx];
`endif
              if (r_rptr == LAST) r_state <= S_WAIT_REL;
            end
          end
          S_WAIT_REL: begin
            // Release only after the loader drops its request
            if (!bus.bios_req) begin
              r_bios_wr       <= 1'b0;
              r_bios_addr     <= r_bios_addr + ADDR_W'(1);
              r_full[r_rbank] <= 1'b0;
              r_rbank         <= ~r_rbank;
              r_state         <= S_IDLE;
            end
          end
          default: r_state <= S_IDLE;
        endcase

        if (r_flush && (r_full == 2'b00) && (r_state == S_IDLE)) r_loaded <= 1'b1;
      end
    end
  end

  assign bus.bios_addr   = r_bios_addr;
  assign bus.bios_din    = r_bios_din;
  assign bus.bios_wr     = r_bios_wr;
  assign bus.bios_loaded = r_loaded;
  assign bus.overflow    = r_overflow;
`ifdef BIOS_DL_CHECKSUM_EN
  assign bus.checksum    = r_checksum;
`endif

endmodule
